// File: rtl/uart_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_param_pkg
// Brief    : Shared constants, parity modes, TX/RX state encoding and parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_param_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_t;

  // Parity bit that makes the data+parity ones count odd or even; unused bits must be zero.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic w_x;
    w_x = ^data;
    return (mode == PAR_ODD) ? ~w_x : (mode == PAR_EVEN) ? w_x : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_param_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_param_if
// Brief    : Host-side valid/ready bundle of the UART (TX request, RX FIFO head, status).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun;
  logic [CNT_W-1:0]     rx_count;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, parity_err, framing_err, overrun, rx_count
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, parity_err, framing_err, overrun, rx_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_param_fifo
// Brief    : Synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_param_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  wire logic                         clkx16,
  input  wire logic                         reset,
  input  wire logic                         i_push,
  input  wire logic                         i_pop,
  input  wire logic [WIDTH-1:0]             i_din,
  output logic      [WIDTH-1:0]             o_dout,
  output logic                              o_full,
  output logic                              o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clkx16 or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= f_next(r_wr);
      end
      if (w_do_pop) r_rd <= f_next(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_param
// Brief    : Full-duplex UART on the 16x clock with RX buffer; define UART_PARAM_FIFO_EN
//            for a FIFO_DEPTH-entry buffer, otherwise a single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_param
  import uart_param_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic   clkx16,
  input  wire logic   reset,
  input  wire logic   i_rx,
  output logic        o_tx,
  uart_param_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef UART_PARAM_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int ENTRY_W   = DATA_BITS + 2;
  localparam logic [3:0] c_last_phase = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] c_mid        = 4'(MID_SAMPLE);
  localparam logic [3:0] c_last_bit   = 4'(DATA_BITS - 1);
  localparam logic       c_last_stop  = 1'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_t          r_tx_state;
  logic [3:0]           r_tx_phase;
  logic [3:0]           r_tx_bit;
  logic                 r_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx;
  logic                 r_tx_ready;

  always_ff @(posedge clkx16 or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_phase <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      if (r_tx_state != ST_IDLE) r_tx_phase <= r_tx_phase + 4'd1;
      case (r_tx_state)
        ST_IDLE: if (bus.tx_valid) begin
          r_tx_shift <= bus.tx_data;
          r_tx_par   <= parity_bit(9'(bus.tx_data), PARITY);
          r_tx_phase <= '0;
          r_tx       <= 1'b0;
          r_tx_ready <= 1'b0;
          r_tx_state <= ST_START;
        end
        ST_START: if (r_tx_phase == c_last_phase) begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= '0;
          r_tx_state <= ST_DATA;
        end
        ST_DATA: if (r_tx_phase == c_last_phase) begin
          if (r_tx_bit != c_last_bit) begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 4'd1;
          end else if (PARITY != PAR_NONE) begin
            r_tx       <= r_tx_par;
            r_tx_state <= ST_PAR;
          end else begin
            r_tx       <= 1'b1;
            r_tx_stop  <= 1'b0;
            r_tx_state <= ST_STOP;
          end
        end
        ST_PAR: if (r_tx_phase == c_last_phase) begin
          r_tx       <= 1'b1;
          r_tx_stop  <= 1'b0;
          r_tx_state <= ST_STOP;
        end
        ST_STOP: if (r_tx_phase == c_last_phase) begin
          if (r_tx_stop == c_last_stop) begin
            r_tx_ready <= 1'b1;
            r_tx_state <= ST_IDLE;
          end else begin
            r_tx_stop  <= 1'b1;
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign bus.tx_ready = r_tx_ready;

  // ---------------- receiver ----------------
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic                 w_rx;
  uart_state_t          r_rx_state;
  logic [3:0]           r_rx_phase;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_perr;
  logic                 r_push;
  logic [ENTRY_W-1:0]   r_entry;

  assign w_rx      = r_sync[1];
  assign w_rx_perr = (PARITY != PAR_NONE) && (parity_bit(9'(r_rx_shift), PARITY) != r_rx_par);

  // The detection cycle counts as phase 0, so every mid-bit sample lands on phase 7.
  always_ff @(posedge clkx16 or posedge reset) begin
    if (reset) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_phase <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_push     <= 1'b0;
      r_entry    <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_rx};
      r_rx_prev  <= w_rx;
      r_push     <= 1'b0;
      r_rx_phase <= r_rx_phase + 4'd1;
      case (r_rx_state)
        ST_IDLE: if (!w_rx && r_rx_prev) begin
          r_rx_phase <= 4'd1;
          r_rx_state <= ST_START;
        end
        ST_START: if (r_rx_phase == c_mid) begin
          r_rx_bit   <= '0;
          r_rx_state <= w_rx ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (r_rx_phase == c_mid) begin
          r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
          r_rx_bit   <= r_rx_bit + 4'd1;
          if (r_rx_bit == c_last_bit)
            r_rx_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
        ST_PAR: if (r_rx_phase == c_mid) begin
          r_rx_par   <= w_rx;
          r_rx_state <= ST_STOP;
        end
        ST_STOP: if (r_rx_phase == c_mid) begin
          r_entry    <= {r_rx_shift, w_rx_perr, ~w_rx};
          r_push     <= 1'b1;
          r_rx_state <= ST_IDLE;
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- receive buffer ----------------
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [BUF_CNT_W-1:0] w_count;
  logic                 w_pop;
  logic                 r_overrun;

  assign w_pop = !w_empty && bus.rx_ready;

  uart_param_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clkx16  (clkx16),
    .reset   (reset),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_entry),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clkx16 or posedge reset) begin
    if (reset)                r_overrun <= 1'b0;
    else if (w_pop)           r_overrun <= 1'b0;
    else if (r_push && w_full) r_overrun <= 1'b1;
  end

  assign bus.rx_valid    = !w_empty;
  assign bus.rx_data     = w_head[ENTRY_W-1:2];
  assign bus.parity_err  = w_head[1];
  assign bus.framing_err = w_head[0];
  assign bus.overrun     = r_overrun;
  assign bus.rx_count    = CNT_W'(w_count);
endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_param
// Brief    : Self-checking bench for two UART configurations (8/odd/1 and 7/even/2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_param;
  logic clkx16 = 1'b0;
  logic reset  = 1'b1;
  always #5 clkx16 = ~clkx16;

`ifdef UART_PARAM_FIFO_EN
  localparam int DEPTH_EFF = 4;
`else
  localparam int DEPTH_EFF = 1;
`endif

  uart_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifb ();

  logic       tx_a, tx_b, rx_a, rx_b;
  logic       loop = 1'b1, drv = 1'b1, sel = 1'b0, h_valid = 1'b0, h_ready = 1'b0;
  logic [8:0] h_data = '0;
  int         nbits = 8, pmode = 1, nstops = 1;
  int         checks = 0, errors = 0;
  bit         fbits[$];

  assign rx_a         = loop ? tx_a : drv;
  assign rx_b         = loop ? tx_b : 1'b1;
  assign ifa.tx_valid = h_valid & ~sel;
  assign ifb.tx_valid = h_valid & sel;
  assign ifa.rx_ready = h_ready & ~sel;
  assign ifb.rx_ready = h_ready & sel;
  assign ifa.tx_data  = h_data[7:0];
  assign ifb.tx_data  = h_data[6:0];

  uart_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clkx16(clkx16), .reset(reset), .i_rx(rx_a), .o_tx(tx_a), .bus(ifa));
  uart_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clkx16(clkx16), .reset(reset), .i_rx(rx_b), .o_tx(tx_b), .bus(ifb));

  logic       c_tx, c_ready, c_valid, c_perr, c_ferr, c_ovr;
  logic [8:0] c_data;
  logic [2:0] c_count;
  assign c_tx    = sel ? tx_b : tx_a;
  assign c_ready = sel ? ifb.tx_ready : ifa.tx_ready;
  assign c_valid = sel ? ifb.rx_valid : ifa.rx_valid;
  assign c_perr  = sel ? ifb.parity_err : ifa.parity_err;
  assign c_ferr  = sel ? ifb.framing_err : ifa.framing_err;
  assign c_ovr   = sel ? ifb.overrun : ifa.overrun;
  assign c_data  = sel ? {2'b00, ifb.rx_data} : {1'b0, ifa.rx_data};
  assign c_count = sel ? ifb.rx_count : ifa.rx_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clkx16);
  endtask

  task automatic set_sel(input bit s);
    sel    = s;
    nbits  = s ? 7 : 8;
    pmode  = s ? 2 : 1;
    nstops = s ? 2 : 1;
  endtask

  // Serial frame as the line should carry it, built from the word format rules.
  function automatic void build_frame(input int data, input bit bad_par, input bit stop_val);
    int ones;
    bit pb;
    fbits.delete();
    fbits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      fbits.push_back(data[i]);
      ones += data[i];
    end
    if (pmode != 0) begin
      pb = (pmode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      fbits.push_back(pb ^ bad_par);
    end
    fbits.push_back(stop_val);
    for (int i = 1; i < nstops; i++) fbits.push_back(1'b1);
  endfunction

  task automatic send(input int data);
    int w = 0;
    while (!c_ready && w < 400) begin @(negedge clkx16); w++; end
    check("send_ready", 32'(c_ready), 32'd1);
    h_data  = 9'(data);
    h_valid = 1'b1;
    @(negedge clkx16);
    h_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int w = 0;
    while (!c_valid && w < limit) begin @(negedge clkx16); w++; end
    check({tag, "_valid"}, 32'(c_valid), 32'd1);
  endtask

  task automatic expect_pop(input string tag, input int data, input bit perr, input bit ferr);
    int m;
    m = (1 << nbits) - 1;
    wait_valid(tag, 400);
    check({tag, "_data"}, 32'(c_data), 32'(data & m));
    check({tag, "_perr"}, 32'(c_perr), 32'(perr));
    check({tag, "_ferr"}, 32'(c_ferr), 32'(ferr));
    h_ready = 1'b1;
    @(negedge clkx16);
    h_ready = 1'b0;
  endtask

  // Called on the first falling clock edge after the accepting edge.
  task automatic check_frame(input string tag, input int data);
    int first;
    int len;
    first = -1;
    build_frame(data, 1'b0, 1'b1);
    len = fbits.size() * 16;
    for (int k = 0; k < len; k++) begin
      check({tag, "_txbit"}, 32'({c_ready, c_tx}), 32'({1'b0, fbits[k / 16]}));
      if (first < 0 && c_valid) first = k;
      @(negedge clkx16);
    end
    check({tag, "_txdone"}, 32'({c_ready, c_tx}), 32'd3);
    if (loop) check({tag, "_rxlat"}, 32'(first), 32'(11 + 16 * (nbits + (pmode != 0 ? 1 : 0) + 1)));
  endtask

  task automatic inject(input int data, input bit bad_par, input bit stop_val);
    build_frame(data, bad_par, stop_val);
    foreach (fbits[i]) begin
      drv = fbits[i];
      tick(16);
    end
    drv = 1'b1;
    tick(4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int q[5];
    bit bp, sv;

    tick(3);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_ready_a", 32'(ifa.tx_ready), 32'd1);
    check("rst_flags_a", 32'({ifa.rx_valid, ifa.parity_err, ifa.framing_err, ifa.overrun}), 32'd0);
    check("rst_count_a", 32'(ifa.rx_count), 32'd0);
    check("rst_tx_b", 32'({ifb.tx_ready, tx_b}), 32'd3);
    reset = 1'b0;
    tick(3);

    // Default configuration, loopback
    set_sel(1'b0);
    send(8'h55);
    check_frame("tx55", 8'h55);
    expect_pop("rx55", 8'h55, 1'b0, 1'b0);
    send(8'hA3);
    send(8'h0F);
    expect_pop("rxA3", 8'hA3, 1'b0, 1'b0);
    expect_pop("rx0F", 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 255));
      send(d);
      expect_pop("rand_loop_a", d, 1'b0, 1'b0);
    end

    // 7 data bits, even parity, two stop bits
    set_sel(1'b1);
    send(7'h41);
    check_frame("tx41", 7'h41);
    expect_pop("rx41", 7'h41, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(0, 127));
      send(d);
      check_frame("rand_tx_b", d);
      expect_pop("rand_loop_b", d, 1'b0, 1'b0);
    end

    // Injected frames on the default instance
    set_sel(1'b0);
    loop = 1'b0;
    tick(20);
    drv = 1'b0;
    tick(5);
    drv = 1'b1;
    tick(200);
    check("false_start_valid", 32'(c_valid), 32'd0);
    check("false_start_count", 32'(c_count), 32'd0);
    inject(8'h3C, 1'b1, 1'b1);
    expect_pop("perr3C", 8'h3C, 1'b1, 1'b0);
    inject(8'h3C, 1'b0, 1'b0);
    expect_pop("ferr3C", 8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 255));
      bp = ($urandom_range(0, 2) == 0);
      sv = ($urandom_range(0, 3) != 0);
      inject(d, bp, sv);
      expect_pop("rand_inject", d, bp, !sv);
    end

    // Overflow with the host not popping
    for (int i = 0; i < 5; i++) begin
      q[i] = int'($urandom_range(0, 255));
      inject(q[i], 1'b0, 1'b1);
    end
    check("ovr_count", 32'(c_count), 32'(DEPTH_EFF));
    check("ovr_set", 32'(c_ovr), 32'd1);
    check("ovr_head", 32'(c_data), 32'(q[0]));
    h_ready = 1'b1;
    @(negedge clkx16);
    h_ready = 1'b0;
    check("ovr_clear", 32'(c_ovr), 32'd0);
    check("ovr_count_pop", 32'(c_count), 32'(DEPTH_EFF - 1));
    for (int i = 1; i < DEPTH_EFF; i++) expect_pop("ovr_drain", q[i], 1'b0, 1'b0);
    check("ovr_empty", 32'(c_valid), 32'd0);

    // Reset in the middle of a transmitted frame, with a word waiting in the buffer
    inject(8'h99, 1'b0, 1'b1);
    check("pre_rst_count", 32'(c_count), 32'd1);
    send(8'hC6);
    tick(48);
    check("mid_frame_busy", 32'(c_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_tx", 32'({c_ready, c_tx}), 32'd3);
    check("rst_mid_count", 32'(c_count), 32'd0);
    check("rst_mid_valid", 32'(c_valid), 32'd0);
    tick(2);
    reset = 1'b0;
    loop  = 1'b1;
    tick(2);
    d = int'($urandom_range(0, 255));
    send(d);
    check_frame("post_rst_tx", d);
    expect_pop("post_rst_rx", d, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
